// File: rtl/fir_out_capture.sv
// ---------------------------------------------------------------------------
// fir_out_capture
//
// Receive-side endpoint for the FIR filter output stream. After an accepted
// start it captures a programmed number of valid samples (Vin/Din, driven by
// the filter's Vout/Dout) into an internal buffer. Once the buffer holds the
// requested count, the samples are read back one per request through a
// simple read port with one cycle of latency.
//
// Optional feature macro: CAPTURE_PEAK_EN
//    defined   : peak tracks max |sample| of the current capture
//    undefined : peak is tied to zero, no register or comparator is built
//
// Ports:
//    clk          rising-edge clock for all logic
//    RST_n        synchronous active-low reset
//    start        arm pulse, honoured only in IDLE
//    num_samples  samples to capture (0 and values > DEPTH mean DEPTH)
//    Vin / Din    sample valid / signed sample from the filter
//    rd_en        read request, honoured only in DONE
//    rd_data      signed read data, holds between reads
//    rd_valid     one-cycle pulse per completed read
//    busy         high while capturing
//    done         high while the buffer is complete and being read out
//    overflow     sticky flag: a valid sample arrived outside CAPTURE
//    capt_count   samples held in the buffer
//    peak         max |sample| of the current capture (see macro above)
// ---------------------------------------------------------------------------
module fir_out_capture #(
   parameter int DATA_W = 13,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     RST_n,
   input  logic                     start,
   input  logic [ADDR_W:0]          num_samples,
   input  logic                     Vin,
   input  logic signed [DATA_W-1:0] Din,
   input  logic                     rd_en,
   output logic signed [DATA_W-1:0] rd_data,
   output logic                     rd_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow,
   output logic [ADDR_W:0]          capt_count,
   output logic [DATA_W-1:0]        peak
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   logic [1:0]        state;
   logic [ADDR_W:0]   target;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   target_clamped;
   logic [ADDR_W:0]   capt_next;
   logic [ADDR_W:0]   rd_next;
   logic              wr_fire;
   logic              rd_fire;
   logic [DATA_W-1:0] mem [DEPTH];

   // A zero request and anything past the buffer size both mean "fill it".
   assign target_clamped = ((num_samples == '0) || (num_samples > DEPTH_CNT))
                           ? DEPTH_CNT : num_samples;

   assign capt_next = capt_count + CNT_ONE;
   assign rd_next   = rd_ptr + CNT_ONE;
   assign wr_fire   = (state == ST_CAPTURE) && Vin;
   assign rd_fire   = (state == ST_DONE) && rd_en && (rd_ptr < capt_count);

   assign busy = (state == ST_CAPTURE);
   assign done = (state == ST_DONE);

   // Control FSM, counters, read port and the sticky overflow flag.
   // capt_count doubles as the write pointer: both are cleared together on
   // start and advance together on every captured sample.
   always_ff @(posedge clk) begin
      if (!RST_n) begin
         state      <= ST_IDLE;
         target     <= '0;
         rd_ptr     <= '0;
         capt_count <= '0;
         overflow   <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  target     <= target_clamped;
                  capt_count <= '0;
                  rd_ptr     <= '0;
                  overflow   <= 1'b0;
                  state      <= ST_CAPTURE;
               end else if (Vin) begin
                  overflow <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               if (Vin) begin
                  capt_count <= capt_next;
                  if (capt_next == target) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (Vin) begin
                  overflow <= 1'b1;
               end
               if (rd_fire) begin
                  rd_data  <= mem[rd_ptr[ADDR_W-1:0]];
                  rd_ptr   <= rd_next;
                  rd_valid <= 1'b1;
                  // The final read returns to IDLE; its rd_valid lands there.
                  if (rd_next == capt_count) begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Sample buffer; contents are don't-care after reset so it has none.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[capt_count[ADDR_W-1:0]] <= Din;
      end
   end

`ifdef CAPTURE_PEAK_EN
   logic [DATA_W-1:0] din_abs;

   // Negating the most negative code wraps to itself, which read as unsigned
   // is exactly its magnitude, so no extra bit is needed.
   assign din_abs = Din[DATA_W-1] ? DATA_W'(-Din) : DATA_W'(Din);

   // Running magnitude peak of the current capture.
   always_ff @(posedge clk) begin
      if (!RST_n) begin
         peak <= '0;
      end else if ((state == ST_IDLE) && start) begin
         peak <= '0;
      end else if (wr_fire && (din_abs > peak)) begin
         peak <= din_abs;
      end
   end
`else
   assign peak = '0;
`endif

endmodule

// File: tb/tb_fir_out_capture.sv
// ---------------------------------------------------------------------------
// tb_fir_out_capture
//
// Self-checking bench for fir_out_capture. A queue-based model tracks what
// the capture endpoint must present after every clock edge; every cycle the
// outputs are compared against it, and literal expectations pin the model
// at the interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_fir_out_capture;

   localparam int DATA_W = 13;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic                     clk = 1'b0;
   logic                     RST_n = 1'b0;
   logic                     start = 1'b0;
   logic [ADDR_W:0]          num_samples = '0;
   logic                     Vin = 1'b0;
   logic signed [DATA_W-1:0] Din = '0;
   logic                     rd_en = 1'b0;
   logic signed [DATA_W-1:0] rd_data;
   logic                     rd_valid;
   logic                     busy;
   logic                     done;
   logic                     overflow;
   logic [ADDR_W:0]          capt_count;
   logic [DATA_W-1:0]        peak;

   int checks = 0;
   int errors = 0;

   // Model: 0 = idle, 1 = capturing, 2 = buffer complete
   int m_phase = 0;
   int m_target = 0;
   int m_buf[$];
   int m_rd_idx = 0;
   int m_rd_data = 0;
   int m_rd_valid = 0;
   int m_overflow = 0;
   int m_peak = 0;

   int rdQ[$];

   fir_out_capture #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk        (clk),
      .RST_n      (RST_n),
      .start      (start),
      .num_samples(num_samples),
      .Vin        (Vin),
      .Din        (Din),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .capt_count (capt_count),
      .peak       (peak)
   );

   always #5 clk = ~clk;

   task automatic checkValue(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs just applied.
   task automatic modelStep();
      int d;
      int a;
      int n;
      d = int'($signed(Din));
      m_rd_valid = 0;
      if (!RST_n) begin
         m_phase = 0;
         m_target = 0;
         m_buf.delete();
         m_rd_idx = 0;
         m_rd_data = 0;
         m_overflow = 0;
         m_peak = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            n = int'(num_samples);
            m_target = (n == 0 || n > DEPTH) ? DEPTH : n;
            m_buf.delete();
            m_rd_idx = 0;
            m_overflow = 0;
            m_peak = 0;
            m_phase = 1;
         end else if (Vin) begin
            m_overflow = 1;
         end
      end else if (m_phase == 1) begin
         if (Vin) begin
            m_buf.push_back(d);
            a = (d < 0) ? -d : d;
            if (a > m_peak) m_peak = a;
            if (m_buf.size() == m_target) m_phase = 2;
         end
      end else begin
         if (Vin) m_overflow = 1;
         if (rd_en && m_rd_idx < m_buf.size()) begin
            m_rd_data = m_buf[m_rd_idx];
            m_rd_idx++;
            m_rd_valid = 1;
            if (m_rd_idx == m_buf.size()) m_phase = 0;
         end
      end
   endtask

   task automatic checkOutput();
      checkValue("busy", int'(busy), (m_phase == 1) ? 1 : 0);
      checkValue("done", int'(done), (m_phase == 2) ? 1 : 0);
      checkValue("overflow", int'(overflow), m_overflow);
      checkValue("capt_count", int'(capt_count), m_buf.size());
      checkValue("rd_valid", int'(rd_valid), m_rd_valid);
      checkValue("rd_data", int'($signed(rd_data)), m_rd_data);
`ifdef CAPTURE_PEAK_EN
      checkValue("peak", int'(peak), m_peak);
`else
      checkValue("peak", int'(peak), 0);
`endif
   endtask

   // One clock cycle: drive on the falling edge, model and compare just
   // after the rising edge.
   task automatic applyStimulus(input bit rst_n, input bit st, input int num,
                                input bit vin, input int din, input bit rd);
      @(negedge clk);
      RST_n = rst_n;
      start = st;
      num_samples = (ADDR_W+1)'(num);
      Vin = vin;
      Din = DATA_W'(din);
      rd_en = rd;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
      if (rd_valid) rdQ.push_back(int'($signed(rd_data)));
   endtask

   task automatic idleCycle();
      applyStimulus(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int t3exp[4];
      t3exp = '{10, -20, 30, -4096};

      // Scenario 1: reset, then stray valid samples while idle
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("t1_reset_busy", int'(busy), 0);
      checkValue("t1_reset_count", int'(capt_count), 0);
      applyStimulus(1, 0, 0, 1, 3, 0);
      checkValue("t1_overflow", int'(overflow), 1);
      applyStimulus(1, 0, 0, 1, 3, 0);
      idleCycle();

      // Scenario 2: four samples with gaps
      applyStimulus(1, 1, 4, 0, 0, 0);
      checkValue("t2_busy", int'(busy), 1);
      checkValue("t2_overflow_cleared", int'(overflow), 0);
      applyStimulus(1, 0, 0, 1, 10, 0);
      idleCycle();
      applyStimulus(1, 0, 0, 1, -20, 0);
      idleCycle();
      applyStimulus(1, 0, 0, 1, 30, 0);
      idleCycle();
      checkValue("t2_not_done_yet", int'(done), 0);
      applyStimulus(1, 0, 0, 1, -4096, 0);
      checkValue("t2_done", int'(done), 1);
      checkValue("t2_count", int'(capt_count), 4);
`ifdef CAPTURE_PEAK_EN
      checkValue("t2_peak", int'(peak), 4096);
`else
      checkValue("t2_peak", int'(peak), 0);
`endif
      idleCycle();

      // Scenario 5: valid sample and start while complete
      applyStimulus(1, 1, 9, 1, 7, 0);
      checkValue("t5_overflow", int'(overflow), 1);
      checkValue("t5_count", int'(capt_count), 4);
      checkValue("t5_done", int'(done), 1);
      idleCycle();

      // Scenario 3: five back-to-back read requests
      rdQ.delete();
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 1);
      checkValue("t3_reads", rdQ.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < rdQ.size()) checkValue("t3_rd_value", rdQ[i], t3exp[i]);
      end
      checkValue("t3_idle_done", int'(done), 0);
      checkValue("t3_count_kept", int'(capt_count), 4);

      // Scenario 4: zero request, then oversize request, both fill DEPTH
      applyStimulus(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 0, 0, 1, i * 100 - 1600, 0);
         if (i == DEPTH - 2) checkValue("t4a_done_early", int'(done), 0);
      end
      checkValue("t4a_done", int'(done), 1);
      checkValue("t4a_count", int'(capt_count), 32);
      rdQ.delete();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 0, 1);
      idleCycle();
      checkValue("t4a_reads", rdQ.size(), 32);
      if (rdQ.size() == 32) checkValue("t4a_last", rdQ[31], 1500);

      applyStimulus(1, 1, 40, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, 0, 0, 1, 2047 - i * 128, 0);
         if (i == 10) idleCycle();
      end
      checkValue("t4b_done", int'(done), 1);
      checkValue("t4b_count", int'(capt_count), 32);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 0, 1);
      idleCycle();

      // Scenario 6: reset mid-capture, then a single-sample capture
      applyStimulus(1, 1, 4, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 111, 0);
      applyStimulus(1, 0, 0, 1, -222, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue("t6_reset_busy", int'(busy), 0);
      checkValue("t6_reset_count", int'(capt_count), 0);
      idleCycle();
      applyStimulus(1, 1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 5, 0);
      checkValue("t6_done", int'(done), 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkValue("t6_rd_valid", int'(rd_valid), 1);
      checkValue("t6_rd_data", int'($signed(rd_data)), 5);
      checkValue("t6_back_idle", int'(done), 0);
      idleCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
